// File: rtl/hex_display_scanner.sv
// ============================================================================
//  Module   : hex_display_scanner
//  Purpose  : Time-multiplexed hex driver for a bank of common-anode digits,
//             with dead time, leading-zero suppression, blink and tear-free
//             double-buffered updates.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_display_scanner #(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    input  logic                lz_en,
    input  logic [DIGITS-1:0]   blink_mask,
    output logic [6:0]          seg_out,
    output logic [DIGITS-1:0]   dig_en_n,
    output logic                frame_start,
    output logic                pending
);

    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] DEAD_END   = SLOT_W'(DEAD_CYCLES);
    localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

    // Counters hold the position of the cycle whose outputs are being
    // registered at the next edge, so the output registers lag by one.
    logic [SLOT_W-1:0]   pos_slot;
    logic [DIG_W-1:0]    pos_digit;
    logic                running;
    logic [4*DIGITS-1:0] display;
    logic [4*DIGITS-1:0] staging;
    logic                blink_phase;
    logic [BLK_W-1:0]    blink_cnt;

    logic                boundary;
    logic                slot_wrap;
    logic [3:0]          cur_nib;
    logic                cur_zero_above;
    logic                cur_mask;
    logic                zero_acc;
    logic                blank;
    logic                lit;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   en_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h18;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // The first edge after reset also sees position (0,0) but is not a boundary.
    assign boundary  = running && (pos_slot == '0) && (pos_digit == '0);
    assign slot_wrap = (pos_slot == SLOT_LAST);

    always_comb begin
        cur_nib        = 4'h0;
        cur_zero_above = 1'b0;
        cur_mask       = 1'b0;
        zero_acc       = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_acc = zero_acc & (display[4*k +: 4] == 4'h0);
            if (DIG_W'(k) == pos_digit) begin
                cur_nib        = display[4*k +: 4];
                cur_zero_above = zero_acc;
                cur_mask       = blink_mask[k];
            end
        end
        blank    = (lz_en && (pos_digit != '0) && cur_zero_above) ||
                   (blink_phase && cur_mask);
        lit      = (pos_slot >= DEAD_END) && !blank;
        seg_next = lit ? hex_to_seg(cur_nib) : 7'h7F;
        en_next  = lit ? ~(DIGITS'(1) << pos_digit) : '1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_slot    <= '0;
            pos_digit   <= '0;
            running     <= 1'b0;
            display     <= '0;
            staging     <= '0;
            pending     <= 1'b0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
            seg_out     <= 7'h7F;
            dig_en_n    <= '1;
            frame_start <= 1'b0;
        end else begin
            running     <= 1'b1;
            seg_out     <= seg_next;
            dig_en_n    <= en_next;
            frame_start <= boundary;

            pos_slot <= slot_wrap ? '0 : pos_slot + 1'b1;
            if (slot_wrap) begin
                pos_digit <= (pos_digit == DIGIT_LAST) ? '0 : pos_digit + 1'b1;
            end

            if (load) begin
                staging <= value;
            end

            if (boundary) begin
                if (load) begin
                    display <= value;
                end else if (pending) begin
                    display <= staging;
                end
                pending <= 1'b0;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
